// File: rtl/spi_eeprom_responder.sv
// SPI mode-0 slave emulating the read side of a 95xxx serial EEPROM (READ 0x03, RDSR 0x05).
// Pins are synchronized into clk; memory contents come from a parallel preload port.
`timescale 1ns/1ps
module spi_eeprom_responder #(
  parameter int MEM_DEPTH = 1024,
  parameter int AW        = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          spi_clk,
  input  logic          mosi,
  input  logic          ss,
  output logic          miso,
  output logic          miso_oe,
  output logic          busy,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [7:0]    load_data,
  output logic [2:0]    state_dbg
);

  // Receive shifter keeps just enough bits for both the command byte and the low AW address bits.
  localparam int RW = (AW > 8) ? AW - 1 : 7;
  localparam logic [7:0] STATUS_BYTE = 8'h00;
  localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    DATA   = 3'd3,
    STATUS = 3'd4,
    IGNORE = 3'd5
  } state_t;

  state_t state, state_next;

  logic sclk_s1, sclk_s2, sclk_d;
  logic mosi_s1, mosi_s2;
  logic ss_s1, ss_s2;

  logic [2:0]    bit_cnt;
  logic          addr_hi;
  logic [RW-1:0] rx;
  logic [7:0]    tx;
  logic [AW-1:0] addr;
  logic [7:0]    mem [MEM_DEPTH];

  logic          rise, fall, byte_done;
  logic [RW:0]   shift_in;
  logic [AW-1:0] fetch_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_d  <= 1'b0;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
      ss_s1   <= 1'b1;
      ss_s2   <= 1'b1;
    end else begin
      sclk_s1 <= spi_clk;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
      ss_s1   <= ss;
      ss_s2   <= ss_s1;
    end
  end

  assign rise       = sclk_s2 & ~sclk_d;
  assign fall       = ~sclk_s2 & sclk_d;
  assign byte_done  = rise && (bit_cnt == 3'd7);
  assign shift_in   = {rx, mosi_s2};
  assign fetch_addr = shift_in[AW-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (!ss_s2) state_next = CMD;
      CMD: begin
        if (byte_done) begin
          case (shift_in[7:0])
            8'h03:   state_next = ADDR;
            8'h05:   state_next = STATUS;
            default: state_next = IGNORE;
          endcase
        end
      end
      ADDR: if (byte_done && addr_hi) state_next = DATA;
      default: state_next = state;
    endcase
    if (ss_s2) state_next = IDLE;
  end

  // Datapath: idle or deselected frames drop any partial byte and quiet miso.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt <= 3'd0;
      addr_hi <= 1'b0;
      rx      <= '0;
      tx      <= 8'h00;
      addr    <= '0;
      miso    <= 1'b0;
    end else if (ss_s2 || state == IDLE) begin
      bit_cnt <= 3'd0;
      addr_hi <= 1'b0;
      rx      <= '0;
      tx      <= 8'h00;
      miso    <= 1'b0;
    end else begin
      case (state)
        CMD: begin
          miso <= 1'b0;
          if (rise) begin
            rx      <= shift_in[RW-1:0];
            bit_cnt <= bit_cnt + 3'd1;
          end
          if (byte_done && shift_in[7:0] == 8'h05) tx <= STATUS_BYTE;
        end
        ADDR: begin
          miso <= 1'b0;
          if (rise) begin
            rx      <= shift_in[RW-1:0];
            bit_cnt <= bit_cnt + 3'd1;
          end
          if (byte_done) begin
            addr_hi <= 1'b1;
            if (addr_hi) begin
              tx   <= mem[fetch_addr];
              addr <= fetch_addr + ADDR_ONE;
            end
          end
        end
        DATA: begin
          if (rise) bit_cnt <= bit_cnt + 3'd1;
          if (byte_done) begin
            tx   <= mem[addr];
            addr <= addr + ADDR_ONE;
          end
          if (fall) begin
            miso <= tx[7];
            tx   <= {tx[6:0], 1'b0};
          end
        end
        STATUS: begin
          if (rise) bit_cnt <= bit_cnt + 3'd1;
          if (byte_done) tx <= STATUS_BYTE;
          if (fall) begin
            miso <= tx[7];
            tx   <= {tx[6:0], 1'b0};
          end
        end
        default: miso <= 1'b0;
      endcase
    end
  end

  // Preload writes land after any same-edge fetch has sampled the old value.
  always_ff @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
  end

  assign busy      = (state != IDLE);
  assign miso_oe   = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_spi_eeprom_responder.sv
// Bench for spi_eeprom_responder: a bit-level SPI master drives frames and compares
// miso bytes against a byte-array model of the EEPROM contents.
`timescale 1ns/1ps
module tb_spi_eeprom_responder;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;
  localparam int CLK   = 10;
  localparam int HALF  = 80;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          spi_clk = 1'b0;
  logic          mosi = 1'b0;
  logic          ss = 1'b1;
  logic          miso, miso_oe, busy;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [7:0]    load_data = '0;
  logic [2:0]    state_dbg;

  logic [7:0] mem_model [DEPTH];
  int n_vec = 0;
  int n_err = 0;

  spi_eeprom_responder #(.MEM_DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .spi_clk(spi_clk), .mosi(mosi), .ss(ss),
    .miso(miso), .miso_oe(miso_oe), .busy(busy),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .state_dbg(state_dbg)
  );

  always #(CLK/2) clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic load_byte(input int a, input logic [7:0] d);
    @(negedge clk);
    load_en   = 1'b1;
    load_addr = AW'(a);
    load_data = d;
    mem_model[a % DEPTH] = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic spi_xfer(input logic [7:0] out_b, output logic [7:0] in_b);
    for (int i = 7; i >= 0; i--) begin
      mosi = out_b[i];
      #HALF;
      in_b[i] = miso;
      spi_clk = 1'b1;
      #HALF;
      spi_clk = 1'b0;
    end
  endtask

  task automatic begin_frame();
    ss = 1'b0;
    #HALF;
  endtask

  task automatic end_frame();
    #HALF;
    ss = 1'b1;
    #(6*CLK);
  endtask

  // Full READ frame; every returned byte and the command phase miso are checked.
  task automatic read_frame(input logic [15:0] start, input int n, input string name);
    logic [7:0] got;
    logic [7:0] exp;
    begin_frame();
    spi_xfer(8'h03, got);
    n_vec++;
    if (got !== 8'h00) begin
      n_err++;
      $display("FAIL %s cmd_miso got=%h want=00", name, got);
    end
    spi_xfer(start[15:8], got);
    spi_xfer(start[7:0], got);
    for (int i = 0; i < n; i++) begin
      spi_xfer(8'($urandom_range(0, 255)), got);
      exp = mem_model[(int'(start) + i) % DEPTH];
      n_vec++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL %s byte%0d addr=%h got=%h want=%h", name, i, start, got, exp);
      end
    end
    n_vec++;
    if (busy !== 1'b1 || miso_oe !== 1'b1) begin
      n_err++;
      $display("FAIL %s in_frame busy=%b oe=%b want 1,1", name, busy, miso_oe);
    end
    end_frame();
    n_vec++;
    if (busy !== 1'b0 || miso_oe !== 1'b0 || miso !== 1'b0) begin
      n_err++;
      $display("FAIL %s after_frame busy=%b oe=%b miso=%b want 0,0,0", name, busy, miso_oe, miso);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    #(3*CLK);
    n_vec++;
    if (miso !== 1'b0 || miso_oe !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs miso=%b oe=%b busy=%b want 0,0,0", miso, miso_oe, busy);
    end
    reset = 1'b0;
    #(3*CLK);
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release busy=%b want 0", busy);
    end
  endtask

  task automatic test_preload();
    for (int a = 0; a < DEPTH; a++) load_byte(a, 8'($urandom_range(0, 255)));
    load_byte(0, 8'hA5);
    load_byte(1, 8'h3C);
    load_byte(DEPTH - 1, 8'h11);
  endtask

  task automatic test_basic_read();
    read_frame(16'h0000, 2, "read_0000");
  endtask

  task automatic test_wrap();
    load_byte(0, 8'h22);
    read_frame(16'h03FF, 2, "wrap_03ff");
    read_frame(16'h0400, 1, "alias_0400");
    load_byte(0, 8'hA5);
  endtask

  task automatic test_status();
    logic [7:0] got;
    begin_frame();
    spi_xfer(8'h05, got);
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (busy !== 1'b1) begin
        n_err++;
        $display("FAIL status_busy byte%0d got=%b want=1", i, busy);
      end
      spi_xfer(8'($urandom_range(0, 255)), got);
      n_vec++;
      if (got !== 8'h00) begin
        n_err++;
        $display("FAIL status_byte%0d got=%h want=00", i, got);
      end
    end
    #HALF;
    ss = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (busy !== 1'b0 || miso_oe !== 1'b0) begin
      n_err++;
      $display("FAIL status_release busy=%b oe=%b want 0,0", busy, miso_oe);
    end
    #(4*CLK);
  endtask

  task automatic test_unknown_cmd();
    logic [7:0] got;
    begin_frame();
    spi_xfer(8'h9F, got);
    spi_xfer(8'hFF, got);
    n_vec++;
    if (got !== 8'h00) begin
      n_err++;
      $display("FAIL ignore_miso got=%h want=00", got);
    end
    end_frame();
    read_frame(16'h0001, 1, "after_ignore");
  endtask

  task automatic test_abort();
    logic [7:0] got;
    begin_frame();
    spi_xfer(8'h03, got);
    spi_xfer(8'h5A, got);
    for (int i = 0; i < 4; i++) begin
      mosi = 1'b1;
      #HALF;
      spi_clk = 1'b1;
      #HALF;
      spi_clk = 1'b0;
    end
    end_frame();
    read_frame(16'h0000, 1, "after_abort");
  endtask

  task automatic test_reset_mid_data();
    logic [7:0] got;
    begin_frame();
    spi_xfer(8'h03, got);
    spi_xfer(8'h00, got);
    spi_xfer(8'h00, got);
    spi_xfer(8'h00, got);
    for (int i = 0; i < 3; i++) begin
      #HALF;
      spi_clk = 1'b1;
      #HALF;
      spi_clk = 1'b0;
    end
    #(HALF/2);
    reset = 1'b1;
    #1;
    n_vec++;
    if (miso !== 1'b0 || miso_oe !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid miso=%b oe=%b busy=%b want 0,0,0", miso, miso_oe, busy);
    end
    ss = 1'b1;
    #(4*CLK - 1);
    reset = 1'b0;
    #(4*CLK);
    read_frame(16'h0000, 1, "after_reset");
  endtask

  task automatic test_random_reads();
    for (int k = 0; k < 12; k++) begin
      read_frame(16'($urandom_range(0, 65535)), $urandom_range(1, 5), "rand_read");
    end
    read_frame(16'hFFFE, 4, "rand_top_wrap");
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) read_frame(16'($urandom_range(1000, 1023)), 3, "b2b_read");
  endtask

  initial begin
    #(10*CLK);
    test_reset();
    test_preload();
    test_basic_read();
    test_wrap();
    test_status();
    test_unknown_cmd();
    test_abort();
    test_reset_mid_data();
    test_random_reads();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
